// File: rtl/pinmux_pkg.sv
// Pinmux configuration types: per-pad target configuration and the attribute
// readback sequencer state encoding.
// No logic; types and constants only.
package pinmux_pkg;

  import prim_pad_wrapper_pkg::*;

  // Expected per-pad configuration; dio_pad_type[i] is the reference for pad i.
  typedef struct packed {
    logic [NDioPads-1:0][2:0] dio_pad_type;
  } target_cfg_t;

  localparam target_cfg_t DefaultTargetCfg = '{dio_pad_type: {NDioPads{B}}};

  typedef enum logic [2:0] {
    AttrRdIdle = 3'h0,
    AttrRdReq  = 3'h1,
    AttrRdGap  = 3'h2,
    AttrRdDone = 3'h3,
    AttrRdErr  = 3'h4
  } attr_rd_state_e;

endpackage

// File: rtl/prim_pad_wrapper_pkg.sv
// Shared pad-wrapper definitions: DIO pad count and the effective pad type encoding.
// No logic; types and constants only.
// Consumers: pinmux_pkg, pinmux_dio_attr_reader.
package prim_pad_wrapper_pkg;

  localparam int unsigned NDioPads = 24;

  // Only A and B are defined; the remaining 3-bit codes are illegal pad responses.
  typedef enum logic [2:0] {
    A = 3'h0,
    B = 3'h1
  } pad_type_e;

endpackage

// File: rtl/pinmux_dio_attr_reader.sv
// Purpose: walks every DIO pad over req/ack, captures its effective pad type and flags target mismatches.
// Latency: 2 cycles per pad with zero-wait acks (done_o in cycle 2*NDioPads after start); +1 per ack wait cycle.
// Backpressure: start_i is dropped while busy_o; a pad that withholds ack for TimeoutCycles ends the scan with error_o.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   start_i / busy_o       scan request / scan in progress
//   done_o                 one-cycle pulse at scan end (success or timeout)
//   error_o, err_idx_o     sticky timeout flag and the pad index that timed out
//   attr_req_o, attr_idx_o readback request and the pad it targets
//   attr_ack_i, attr_type_i pad response (same-cycle ack allowed)
//   dio_pad_type_o         captured per-pad types
//   mismatch_o             per-pad captured != target flags
module pinmux_dio_attr_reader
  import prim_pad_wrapper_pkg::*;
  import pinmux_pkg::*;
#(
  parameter target_cfg_t TargetCfg     = DefaultTargetCfg,
  parameter int unsigned TimeoutCycles = 16,
  localparam int unsigned IdxW         = $clog2(NDioPads),
  localparam int unsigned CntW         = $clog2(TimeoutCycles + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [IdxW-1:0]     err_idx_o,
  output logic                attr_req_o,
  output logic [IdxW-1:0]     attr_idx_o,
  input  logic                attr_ack_i,
  input  pad_type_e           attr_type_i,
  output pad_type_e           dio_pad_type_o [NDioPads],
  output logic [NDioPads-1:0] mismatch_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDioPads - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  attr_rd_state_e      state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                error_q, error_d;
  logic [IdxW-1:0]     err_idx_q, err_idx_d;
  logic [NDioPads-1:0] mismatch_q, mismatch_d;
  pad_type_e           dio_pad_type_q [NDioPads];
  pad_type_e           dio_pad_type_d [NDioPads];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= AttrRdIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The ack on the last pad goes straight to DONE: the
  // request-dropping gap only exists to separate consecutive pads, so skipping
  // it on the final pad puts done_o in cycle 2*NDioPads.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AttrRdIdle: begin
        if (start_i) state_d = AttrRdReq;
      end
      AttrRdReq: begin
        if (attr_ack_i) begin
          state_d = (idx_q == LastIdx) ? AttrRdDone : AttrRdGap;
        end else if (cnt_q == CntLast) begin
          state_d = AttrRdErr;
        end
      end
      AttrRdGap: begin
        state_d = (idx_q == LastIdx) ? AttrRdDone : AttrRdReq;
      end
      AttrRdDone, AttrRdErr: begin
        // A start arriving here is deliberately dropped.
        state_d = AttrRdIdle;
      end
      default: state_d = AttrRdIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    busy_o     = (state_q != AttrRdIdle);
    attr_req_o = (state_q == AttrRdReq);
    done_o     = (state_q == AttrRdDone) || (state_q == AttrRdErr);
  end

  // Datapath next-state: index walk, timeout counter, capture and error latch.
  always_comb begin
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    error_d        = error_q;
    err_idx_d      = err_idx_q;
    mismatch_d     = mismatch_q;
    dio_pad_type_d = dio_pad_type_q;
    unique case (state_q)
      AttrRdIdle: begin
        if (start_i) begin
          idx_d      = '0;
          cnt_d      = '0;
          error_d    = 1'b0;
          mismatch_d = '0;
        end
      end
      AttrRdReq: begin
        if (attr_ack_i) begin
          // Illegal codes are stored raw; they can never equal a legal target.
          dio_pad_type_d[idx_q] = attr_type_i;
          mismatch_d[idx_q]     = (3'(attr_type_i) != TargetCfg.dio_pad_type[idx_q]);
        end else if (cnt_q == CntLast) begin
          error_d   = 1'b1;
          err_idx_d = idx_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      AttrRdGap: begin
        if (idx_q != LastIdx) begin
          idx_d = idx_q + IdxW'(1);
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      mismatch_q <= '0;
      for (int i = 0; i < NDioPads; i++) begin
        dio_pad_type_q[i] <= A;
      end
    end else begin
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      error_q        <= error_d;
      err_idx_q      <= err_idx_d;
      mismatch_q     <= mismatch_d;
      dio_pad_type_q <= dio_pad_type_d;
    end
  end

  assign attr_idx_o     = idx_q;
  assign error_o        = error_q;
  assign err_idx_o      = err_idx_q;
  assign mismatch_o     = mismatch_q;
  assign dio_pad_type_o = dio_pad_type_q;

endmodule
